serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 116 +++++++++++
 tb/tb_serial_add_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full-adder cell (optional ovf: SERIAL_ADD_OVF_EN)

module fa (
    output logic co,
    output logic s,
    input  logic ci,
    input  logic x,
    input  logic y
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [N-1:0]    a_sh, b_sh, sum_shifted;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            fa_s, fa_co;

    fa u_fa (
        .co (fa_co),
        .s  (fa_s),
        .ci (carry),
        .x  (a_sh[0]),
        .y  (b_sh[0])
    );

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        sum_shifted = sum >> 1;
        sum_shifted[N-1] = fa_s;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= cin;
                    cnt   <= '0;
                    sum   <= '0;
                    cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf   <= 1'b0;
`endif
                end
                RUN: begin
                    sum   <= sum_shifted;
                    carry <= fa_co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    // Final bit: its carry-out is the sum's carry, ci^co of the MSB is signed overflow
                    if (cnt == LAST) begin
                        cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf  <= carry ^ fa_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl (N=8 and N=1 instances)

module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       cout8, busy8, done8, ovf8;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    logic       cout1, busy1, done1, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_add_ctrl #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf8 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs(input int w);
        // {ovf, cout, sum[7:0]}
        if (w == 8) return {ovf8, cout8, sum8};
        return {ovf1, cout1, 7'd0, sum1};
    endfunction

    // One addition on the selected instance; optional noise re-pulses start with junk operands while busy
    task automatic do_op(input int w, input logic [7:0] aa, input logic [7:0] bb, input logic cc, input bit noise);
        logic [8:0] full;
        logic       exp_ovf;
        logic [9:0] o;
        int cyc, busy_cnt, done_cnt;
        full = (w == 8) ? ({1'b0, aa} + {1'b0, bb} + 9'(cc))
                        : 9'(aa[0]) + 9'(bb[0]) + 9'(cc);
        if (w == 8) exp_ovf = (aa[7] == bb[7]) && (full[7] != aa[7]);
        else        exp_ovf = (aa[0] == bb[0]) && (full[0] != aa[0]);
        @(negedge clk);
        if (w == 8) begin start8 = 1'b1; a8 = aa; b8 = bb; cin8 = cc; end
        else        begin start1 = 1'b1; a1 = aa[0]; b1 = bb[0]; cin1 = cc; end
        @(posedge clk);
        cyc = 0; busy_cnt = 0; done_cnt = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if ((w == 8) ? busy8 : busy1) busy_cnt++;
            if ((w == 8) ? done8 : done1) begin done_cnt++; break; end
            if (w == 8) begin
                start8 = noise ? 1'($urandom) : 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end else begin
                start1 = noise ? 1'($urandom) : 1'b0;
                a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            end
        end
        // Start stays high through DONE when noisy, to prove it is ignored there
        if (w == 8) start8 = noise; else start1 = noise;
        check("done_seen", 64'(done_cnt), 64'd1);
        check("latency", 64'(cyc), 64'(w + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(w + 1));
        o = outs(w);
        if (w == 8) check("sum_cout", 64'({o[8], o[7:0]}), 64'(full));
        else        check("sum_cout", 64'({o[8], o[0]}), 64'(full[1:0]));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 64'(o[9]), 64'(exp_ovf));
`else
        if (exp_ovf) ; // overflow not observable in this build
`endif
        @(negedge clk);
        if (w == 8) start8 = 1'b0; else start1 = 1'b0;
        check("done_single", 64'((w == 8) ? done8 : done1), 64'd0);
        check("idle_busy", 64'((w == 8) ? busy8 : busy1), 64'd0);
        check("sum_held", 64'(outs(w)), 64'(o));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs8", 64'({ovf8, cout8, sum8, busy8, done8}), 64'd0);
        check("rst_outs1", 64'({ovf1, cout1, sum1, busy1, done1}), 64'd0);
        rst = 1'b0;

        do_op(8, 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8, 8'h55, 8'hAA, 1'b1, 1'b0);
        do_op(8, 8'h03, 8'h04, 1'b0, 1'b0);
        do_op(8, 8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8, 8'h80, 8'h80, 1'b0, 1'b0);
        do_op(8, 8'h12, 8'h34, 1'b0, 1'b1);

        // Abort on the 4th RUN cycle, with a start request in the reset cycle
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
        @(posedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        check("abort_outs", 64'({ovf8, cout8, sum8, busy8, done8}), 64'd0);
        rst = 1'b0; start8 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done8), 64'd0);
        end
        do_op(8, 8'hC3, 8'h3C, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++)
            do_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        for (int i = 0; i < 8; i++)
            do_op(1, 8'(i[2]), 8'(i[1]), i[0], 1'b0);
        for (int i = 0; i < 6; i++)
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
